mio_bus_ctrl: RTL and testbench
===============================

Name: mio_bus_ctrl

Overview:
- Parametrised memory-mapped I/O bus controller between the CPU data port and the data RAM plus on-board peripherals.
- Adds a req/ready handshake and a registered response path.
- Adds synchronised switch input with sticky change flags (write-1-to-clear).
- Holds SEG7 and LED output registers and a loadable free-running cycle counter.
- Returns a bus-error pulse on unmapped I/O offsets. All other addresses route to the synchronous-read data RAM.

Parameters:
- RAM_AW, 7, RAM word-address width (ram_addr = cpu_addr[RAM_AW+1:2])
- SW_W, 16, switch input width (≤32)
- LED_W, 16, LED output width (≤32)
- IO_BASE, 32'hFFFF0000, base of I/O window; window = IO_BASE..IO_BASE+0xFF
- SYNC_STAGES, 2, flip-flop stages on sw_i (≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  access request; addr/wdata/we/amp valid while high
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_amp  in  4  byte-enable / access pattern
- cpu_rdata  out  32  read data, valid when cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- bus_err  out  1  one-cycle pulse with cpu_ready on unmapped I/O offset
- sw_i  in  SW_W  asynchronous switch input
- ram_addr  out  RAM_AW  RAM word address
- ram_wdata  out  32  RAM write data
- ram_we  out  1  RAM write strobe
- ram_amp  out  4  RAM byte enables
- ram_rdata  in  32  RAM read data, valid the cycle after address
- seg7_data  out  32  registered 7-segment value
- seg7_we  out  1  one-cycle pulse on SEG7 write
- led_o  out  LED_W  registered LED value

Behaviour:
- FSM states IDLE, RESP.
  - IDLE & cpu_req → RESP.
  - RESP → IDLE unconditionally.
  - Throughput: one access per 2 cycles. cpu_ready=1 only in RESP. The CPU holds cpu_req and inputs stable until it sees cpu_ready.
- The request is accepted in the IDLE cycle with cpu_req=1. At acceptance, the controller latches is_io = (cpu_addr[31:8]==IO_BASE[31:8]), offset[7:0] and we.
- RAM access:
  - When !is_io, drive ram_addr/ram_wdata/ram_amp from the CPU inputs in the accept cycle.
  - ram_we = cpu_we for exactly that cycle.
  - In RESP, cpu_rdata = ram_rdata for reads and 0 for writes.
  - Outside the accept cycle: ram_we=0, ram_amp=0, ram_addr=0.
- I/O map (offset, access):
  - 0x04 SW, read-only: {zero-extend, sw_sync}. Writes are ignored, no error.
  - 0x08 SW_CHG, read / write-1-to-clear. Bit i sets when sw_sync[i] differs from its previous value.
  - 0x0C SEG7, read/write. A write updates seg7_data and pulses seg7_we in RESP.
  - 0x10 LED, read/write. A write updates led_o using wdata[LED_W-1:0].
  - 0x14 CYCLES, read/write. Increments every cycle with 32-bit wrap. A write loads wdata.
  - Any other offset: read returns 0, write has no effect, bus_err=1 in RESP.
- I/O register writes occur at the accept edge (IDLE→RESP). cpu_amp is ignored for I/O (full-word).
- I/O read data is registered at the accept edge and presented in RESP.
  - CYCLES returns its value at the accept edge.
- Simultaneous events:
  - SW_CHG set and W1C on the same bit in the same cycle → set wins.
  - CYCLES write and increment in the same cycle → write wins (next value = wdata).
- sw_sync is the output of a SYNC_STAGES flip-flop chain. Change detection compares sw_sync against a one-more-stage delayed copy.
- Reset values:
  - state=IDLE; cpu_ready=0, bus_err=0, cpu_rdata=0.
  - seg7_data=0, seg7_we=0, led_o=0.
  - CYCLES=0, SW_CHG=0, sync chain=0.
  - All RAM outputs 0.
- Reset in RESP: abort to IDLE, no cpu_ready pulse, no pending write committed after reset.

Decomposition:
- Package mio_pkg: I/O offset constants (OFF_SW, OFF_SW_CHG, OFF_SEG7, OFF_LED, OFF_CYCLES) and state enum {IDLE, RESP}.
- One sub-module: sw_sync_edge (SW_W, SYNC_STAGES). Holds the synchroniser chain, the delayed copy, and the sticky W1C change register; outputs sw_sync and sw_chg.

Test Plan:
- Reset, then RAM write to addr 0x00000010, wdata 0xDEADBEEF, amp 4'hF → in the accept cycle ram_we=1, ram_addr=4, ram_amp=F; cpu_ready pulses next cycle. A subsequent read returns 0xDEADBEEF from the RAM model.
- Write 0x12345678 to 0xFFFF000C → seg7_we pulses once in RESP; seg7_data=0x12345678. Read-back of 0xFFFF000C returns 0x12345678. ram_we stays 0 throughout.
- sw_i changes 0x0000→0x0005 → after SYNC_STAGES cycles a read of 0xFFFF0004 returns 0x5 and SW_CHG=0x5. Write 0x1 to 0xFFFF0008 → SW_CHG=0x4. Toggle bit 0 coincident with that W1C → bit 0 remains 1.
- Write 0xFFFFFFFE to 0xFFFF0014, idle 3 cycles, read → value wrapped to 0x00000001 or later; the counter wraps without error.
- Read 0xFFFF0020 → cpu_rdata=0, bus_err=1 with cpu_ready. Write 0xFFFF0004 → no error, no state change.
- Assert rst during RESP of a LED write → cpu_ready never pulses, led_o=0 after reset, state returns to IDLE.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared definitions for the MMIO bus controller: I/O register offsets and FSM states.
package mio_pkg;

  localparam int unsigned OFF_W = 8;

  localparam logic [OFF_W-1:0] OFF_SW     = 8'h04;
  localparam logic [OFF_W-1:0] OFF_SW_CHG = 8'h08;
  localparam logic [OFF_W-1:0] OFF_SEG7   = 8'h0C;
  localparam logic [OFF_W-1:0] OFF_LED    = 8'h10;
  localparam logic [OFF_W-1:0] OFF_CYCLES = 8'h14;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

endpackage

// File: rtl/sw_sync_edge.sv
// Switch input synchroniser with sticky per-bit change flags (write-1-to-clear, set wins).
module sw_sync_edge #(
  parameter int unsigned SW_W        = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw_i,
  input  logic            clr_en,
  input  logic [SW_W-1:0] clr_mask,
  output logic [SW_W-1:0] sw_sync,
  output logic [SW_W-1:0] sw_chg
);

  logic [SYNC_STAGES-1:0][SW_W-1:0] chain_q;
  logic [SW_W-1:0]                  sw_dly_q;
  logic [SW_W-1:0]                  clr_c;

  assign sw_sync = chain_q[SYNC_STAGES-1];
  assign clr_c   = clr_en ? clr_mask : '0;

  // Stage 0 samples the raw input; sw_dly_q trails sw_sync by one cycle for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q  <= '0;
      sw_dly_q <= '0;
      sw_chg   <= '0;
    end else begin
      chain_q  <= {chain_q[SYNC_STAGES-2:0], sw_i};
      sw_dly_q <= sw_sync;
      sw_chg   <= (sw_chg & ~clr_c) | (sw_sync ^ sw_dly_q);
    end
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// CPU data-port bus controller: routes accesses to the data RAM or the on-board I/O window
// with a two-cycle req/ready handshake.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int unsigned RAM_AW      = 7,
  parameter int unsigned SW_W        = 16,
  parameter int unsigned LED_W       = 16,
  parameter logic [31:0] IO_BASE     = 32'hFFFF0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_amp,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              bus_err,
  input  logic [SW_W-1:0]   sw_i,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic [3:0]        ram_amp,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       seg7_data,
  output logic              seg7_we,
  output logic [LED_W-1:0]  led_o
);

  state_t state_q, state_d;

  logic             accept;
  logic             is_io;
  logic             io_wr;
  logic             io_hit;
  logic [OFF_W-1:0] offset;
  logic [31:0]      io_val;

  logic             is_io_q, we_q, err_q, seg7_wr_q;
  logic [31:0]      io_rdata_q;
  logic [31:0]      cycles_q;

  logic [SW_W-1:0]  sw_sync, sw_chg;

  assign is_io  = (cpu_addr[31:8] == IO_BASE[31:8]);
  assign offset = cpu_addr[OFF_W-1:0];
  assign io_wr  = accept && is_io && cpu_we;

  sw_sync_edge #(
    .SW_W        (SW_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sw_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .sw_i     (sw_i),
    .clr_en   (io_wr && (offset == OFF_SW_CHG)),
    .clr_mask (cpu_wdata[SW_W-1:0]),
    .sw_sync  (sw_sync),
    .sw_chg   (sw_chg)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Handshake, RAM strobes and response mux; a reset during RESP suppresses the response.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    ram_amp   = '0;
    cpu_ready = 1'b0;
    bus_err   = 1'b0;
    seg7_we   = 1'b0;
    cpu_rdata = '0;
    case (state_q)
      IDLE: begin
        if (cpu_req && !rst) begin
          state_d = RESP;
          accept  = 1'b1;
          if (!is_io) begin
            ram_addr  = cpu_addr[RAM_AW+1:2];
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we;
            ram_amp   = cpu_amp;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        if (!rst) begin
          cpu_ready = 1'b1;
          bus_err   = err_q;
          seg7_we   = seg7_wr_q;
          cpu_rdata = is_io_q ? io_rdata_q : (we_q ? '0 : ram_rdata);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io_val = '0;
    io_hit = 1'b1;
    case (offset)
      OFF_SW:     io_val = 32'(sw_sync);
      OFF_SW_CHG: io_val = 32'(sw_chg);
      OFF_SEG7:   io_val = seg7_data;
      OFF_LED:    io_val = 32'(led_o);
      OFF_CYCLES: io_val = cycles_q;
      default:    io_hit = 1'b0;
    endcase
  end

  // Request attributes, I/O read data and I/O register writes all land on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_io_q    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      seg7_wr_q  <= 1'b0;
      io_rdata_q <= '0;
      cycles_q   <= '0;
      seg7_data  <= '0;
      led_o      <= '0;
    end else begin
      cycles_q <= (io_wr && (offset == OFF_CYCLES)) ? cpu_wdata : cycles_q + 32'd1;
      if (accept) begin
        is_io_q    <= is_io;
        we_q       <= cpu_we;
        err_q      <= is_io && !io_hit;
        seg7_wr_q  <= io_wr && (offset == OFF_SEG7);
        io_rdata_q <= (is_io && !cpu_we) ? io_val : '0;
      end
      if (io_wr && (offset == OFF_SEG7)) seg7_data <= cpu_wdata;
      if (io_wr && (offset == OFF_LED))  led_o     <= cpu_wdata[LED_W-1:0];
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Randomised self-checking bench for mio_bus_ctrl against an edge-indexed behavioural model.
module tb_mio_bus_ctrl;

  localparam int unsigned RAM_AW      = 7;
  localparam int unsigned SW_W        = 16;
  localparam int unsigned LED_W       = 16;
  localparam int unsigned SYNC_STAGES = 2;
  localparam logic [31:0] IO_BASE     = 32'hFFFF0000;
  localparam int          S           = int'(SYNC_STAGES);
  localparam int          HN          = 8192;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [31:0]       cpu_addr, cpu_wdata;
  logic [3:0]        cpu_amp;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready, bus_err;
  logic [SW_W-1:0]   sw_i;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic [3:0]        ram_amp;
  logic [31:0]       ram_rdata;
  logic [31:0]       seg7_data;
  logic              seg7_we;
  logic [LED_W-1:0]  led_o;

  always #5 clk = ~clk;

  mio_bus_ctrl #(
    .RAM_AW      (RAM_AW),
    .SW_W        (SW_W),
    .LED_W       (LED_W),
    .IO_BASE     (IO_BASE),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_amp   (cpu_amp),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .bus_err   (bus_err),
    .sw_i      (sw_i),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_amp   (ram_amp),
    .ram_rdata (ram_rdata),
    .seg7_data (seg7_data),
    .seg7_we   (seg7_we),
    .led_o     (led_o)
  );

  // Synchronous-read data RAM with byte enables.
  logic [31:0] ram_mem [2**RAM_AW];
  always @(posedge clk) begin
    ram_rdata <= ram_mem[ram_addr];
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_amp[b]) ram_mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
  end

  // Reference model state
  int              n_checks = 0;
  int              n_fail   = 0;
  int              edge_n   = 0;
  int              rst_edge = 0;
  int              w1c_edge = -1;
  logic [SW_W-1:0] w1c_mask = '0;
  int              cyc_wr_edge = -1;
  logic [31:0]     cyc_wr_val  = '0;
  logic [SW_W-1:0] hist [HN];
  logic [SW_W-1:0] chg_ref = '0;
  logic [31:0]     seg7_ref = '0;
  logic [LED_W-1:0] led_ref = '0;
  logic [31:0]     ref_mem [int];

  // Switch value sampled at edge k; anything at or before the last reset edge reads as zero.
  function automatic logic [SW_W-1:0] sw_at(input int k);
    if (k <= rst_edge) return '0;
    return hist[k % HN];
  endfunction

  function automatic logic [31:0] cyc_expect(input int e);
    if (cyc_wr_edge > rst_edge) return cyc_wr_val + 32'(e - 1 - cyc_wr_edge);
    return 32'(e - 1 - rst_edge);
  endfunction

  // Per-edge bookkeeping: input history, reset points, sticky change flags.
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    hist[edge_n % HN] = sw_i;
    if (rst) begin
      rst_edge = edge_n;
      chg_ref  = '0;
    end else begin
      chg_ref = (chg_ref & ~((edge_n == w1c_edge) ? w1c_mask : '0))
              | (sw_at(edge_n - S) ^ sw_at(edge_n - S - 1));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete CPU access starting from IDLE; checks accept cycle, response and return to idle.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] amp);
    logic              io;
    logic [7:0]        off;
    logic [31:0]       exp_rd, chg_snap, cur;
    logic              exp_err, exp_seg;
    logic [RAM_AW-1:0] w;
    int                e;
    io       = (addr[31:8] == IO_BASE[31:8]);
    off      = addr[7:0];
    w        = addr[RAM_AW+1:2];
    chg_snap = 32'(chg_ref);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_amp   = amp;
    if (io && we && off == 8'h08) begin
      w1c_edge = edge_n + 1;
      w1c_mask = wdata[SW_W-1:0];
    end
    #1;
    check("acc_ram_we",    32'(ram_we),    32'(!io && we));
    check("acc_ram_addr",  32'(ram_addr),  io ? 32'd0 : 32'(w));
    check("acc_ram_amp",   32'(ram_amp),   io ? 32'd0 : 32'(amp));
    check("acc_ram_wdata", ram_wdata,      io ? 32'd0 : wdata);
    check("acc_ready",     32'(cpu_ready), 32'd0);
    @(posedge clk);
    #1;
    e       = edge_n;
    exp_rd  = '0;
    exp_err = 1'b0;
    exp_seg = 1'b0;
    if (!io) begin
      cur = ref_mem.exists(int'(w)) ? ref_mem[int'(w)] : 32'd0;
      if (we) begin
        for (int b = 0; b < 4; b++) if (amp[b]) cur[8*b +: 8] = wdata[8*b +: 8];
        ref_mem[int'(w)] = cur;
      end else begin
        exp_rd = cur;
      end
    end else begin
      case (off)
        8'h04: if (!we) exp_rd = 32'(sw_at(e - S));
        8'h08: if (!we) exp_rd = chg_snap;
        8'h0C: if (we) begin seg7_ref = wdata; exp_seg = 1'b1; end else exp_rd = seg7_ref;
        8'h10: if (we) led_ref = wdata[LED_W-1:0]; else exp_rd = 32'(led_ref);
        8'h14: if (we) begin cyc_wr_val = wdata; cyc_wr_edge = e; end else exp_rd = cyc_expect(e);
        default: exp_err = 1'b1;
      endcase
    end
    check("resp_ready",   32'(cpu_ready), 32'd1);
    check("resp_err",     32'(bus_err),   32'(exp_err));
    check("resp_rdata",   cpu_rdata,      exp_rd);
    check("resp_seg7_we", 32'(seg7_we),   32'(exp_seg));
    check("resp_seg7",    seg7_data,      seg7_ref);
    check("resp_led",     32'(led_o),     32'(led_ref));
    check("resp_ram_we",  32'(ram_we),    32'd0);
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ready", 32'(cpu_ready), 32'd0);
  endtask

  initial begin
    logic [7:0] off;
    for (int i = 0; i < 2**RAM_AW; i++) ram_mem[i] = '0;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_amp   = '0;
    sw_i      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_err",   32'(bus_err),   32'd0);
    check("rst_rdata", cpu_rdata,      32'd0);
    check("rst_seg7",  seg7_data,      32'd0);
    check("rst_seg_we", 32'(seg7_we),  32'd0);
    check("rst_led",   32'(led_o),     32'd0);
    check("rst_ram_we", 32'(ram_we),   32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    rst = 1'b0;

    // RAM write then read-back
    access(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF);
    access(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    check("ram_readback", cpu_rdata, 32'h0);
    // SEG7 write and read-back
    access(1'b1, 32'hFFFF_000C, 32'h12345678, 4'hF);
    access(1'b0, 32'hFFFF_000C, 32'h0, 4'h0);
    // switch sync, change flags, W1C, coincident set
    sw_i = 16'h0005;
    repeat (S + 2) @(posedge clk);
    #1;
    access(1'b0, 32'hFFFF_0004, 32'h0, 4'h0);
    access(1'b0, 32'hFFFF_0008, 32'h0, 4'h0);
    access(1'b1, 32'hFFFF_0008, 32'h1, 4'h0);
    access(1'b0, 32'hFFFF_0008, 32'h0, 4'h0);
    sw_i = sw_i ^ 16'h0001;
    repeat (S) @(posedge clk);
    #1;
    access(1'b1, 32'hFFFF_0008, 32'h1, 4'h0);
    access(1'b0, 32'hFFFF_0008, 32'h0, 4'h0);
    // counter load and wrap
    access(1'b1, 32'hFFFF_0014, 32'hFFFF_FFFE, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    access(1'b0, 32'hFFFF_0014, 32'h0, 4'h0);
    // unmapped offset and write to read-only SW
    access(1'b0, 32'hFFFF_0020, 32'h0, 4'h0);
    access(1'b1, 32'hFFFF_0004, 32'hFFFF_FFFF, 4'hF);
    access(1'b0, 32'hFFFF_0004, 32'h0, 4'h0);
    // reset arriving during the response of an LED write
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'hFFFF_0010;
    cpu_wdata = 32'h0000_ABCD;
    @(posedge clk);
    #1;
    rst     = 1'b1;
    cpu_req = 1'b0;
    #1;
    check("rstresp_ready", 32'(cpu_ready), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    led_ref  = '0;
    seg7_ref = '0;
    check("rstresp_led",   32'(led_o),     32'd0);
    check("rstresp_idle",  32'(cpu_ready), 32'd0);
    access(1'b0, 32'hFFFF_0010, 32'h0, 4'h0);
    access(1'b0, 32'hFFFF_0014, 32'h0, 4'h0);

    // randomised traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) sw_i = SW_W'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      case ($urandom_range(0, 7))
        0, 1, 2: access(1'($urandom), {1'b0, 31'($urandom)}, $urandom, 4'($urandom));
        default: begin
          case ($urandom_range(0, 5))
            0: off = 8'h04;
            1: off = 8'h08;
            2: off = 8'h0C;
            3: off = 8'h10;
            4: off = 8'h14;
            default: begin
              off = 8'($urandom);
              if (off inside {8'h04, 8'h08, 8'h0C, 8'h10, 8'h14}) off = 8'h18;
            end
          endcase
          access(1'($urandom), {IO_BASE[31:8], off}, $urandom, 4'($urandom));
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
